// File: rtl/muldiv_pkg.sv
// muldiv_pkg: constants and types shared by the multiply/divide unit, the
// pipeline controller and the writeback mux.
//   MD_WIDTH       default operand / HI / LO width
//   MD_MULT..DIVU  op encodings driven on muldiv_unit.op
//   md_state_e     FSM state encoding (IDLE, CALC, FIX)
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // op[0] clear marks the signed variants; op[1] set marks the divides.
  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negation. Used to take
// operand magnitudes on the way in and to re-apply result signs on the way
// out.
//   i_val  value to pass through or negate
//   i_neg  1 = output -i_val, 0 = output i_val
//   o_val  result, same width as i_val
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  logic [W-1:0] w_one;
  assign w_one = {{(W-1){1'b0}}, 1'b1};
  assign o_val = i_neg ? ((~i_val) + w_one) : i_val;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply / divide unit with architectural HI/LO.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   start, op     launch MULT/MULTU/DIV/DIVU; sampled only while idle
//   SrcA, SrcB    operands (SrcA is also the MTHI/MTLO data)
//   mthi, mtlo    write SrcA to HI / LO; honoured only when idle and start=0
//   busy          operation in flight (state != IDLE); controller stalls on it
//   done          one-cycle pulse after HI/LO were updated by an operation
//   hi, lo        HI / LO registers
//   o_dbg_state   current FSM state (md_state_e encoding)
// Handshake: start is a request with no ready; it is accepted on any edge
// where busy=0, and ignored (not queued) while busy=1. Completion is the done
// pulse, WIDTH+1 edges after acceptance.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  md_state_e          r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_q, r_neg_r, r_done;
  logic [WIDTH-1:0]   r_b, r_hi, r_lo;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] r_acc;

  logic               w_sgn, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q, w_r;
  logic [2*WIDTH-1:0] w_prod, w_mul_nxt, w_div_nxt;
  logic [WIDTH:0]     w_mul_sum, w_div_trial;
  logic [WIDTH+1:0]   w_div_diff;

  assign w_sgn    = md_is_signed(op);
  assign w_b_zero = (SrcB == '0);

  muldiv_sign_fix #(.W(WIDTH)) u_mag_a (
    .i_val(SrcA), .i_neg(w_sgn & SrcA[WIDTH-1]), .o_val(w_a_mag));
  muldiv_sign_fix #(.W(WIDTH)) u_mag_b (
    .i_val(SrcB), .i_neg(w_sgn & SrcB[WIDTH-1]), .o_val(w_b_mag));

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right one place.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: the trial remainder needs WIDTH+1 bits, the subtraction
  // one more so its top bit is a clean borrow flag.
  assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_diff  = {1'b0, w_div_trial} - {2'b00, r_b};
  assign w_div_nxt   = w_div_diff[WIDTH+1]
                     ? {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

  // r_neg_q also carries the product sign for multiplies.
  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .i_val(r_acc), .i_neg(r_neg_q), .o_val(w_prod));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (
    .i_val(r_acc[WIDTH-1:0]), .i_neg(r_neg_q), .o_val(w_q));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .i_val(r_acc[2*WIDTH-1:WIDTH]), .i_neg(r_neg_r), .o_val(w_r));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_is_div <= md_is_div(op);
            r_b      <= w_b_mag;
            r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
            r_cnt    <= '0;
            // Divide by zero keeps raw magnitudes: no sign is applied.
            r_neg_q  <= w_sgn & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]) & ~(md_is_div(op) & w_b_zero);
            r_neg_r  <= w_sgn & md_is_div(op) & SrcA[WIDTH-1] & ~w_b_zero;
          end else begin
            if (mthi) r_hi <= SrcA;
            if (mtlo) r_lo <= SrcA;
          end
        end
        CALC: begin
          r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
        FIX: begin
          if (r_is_div) begin
            r_lo <= w_q;
            r_hi <= w_r;
          end else begin
            {r_hi, r_lo} <= w_prod;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] SrcA, SrcB;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .SrcA(SrcA), .SrcB(SrcB),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .o_dbg_state(dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: {hi, lo} ----------------
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          q, r;
    longint unsigned uq, ur;
    logic [31:0]     amag;
    case (o)
      MD_MULT:  return 64'(sa * sb);
      MD_MULTU: return 64'(ua * ub);
      MD_DIV: begin
        if (b == 32'd0) begin
          amag = a[31] ? 32'(-sa) : a;
          return {amag, 32'hFFFF_FFFF};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  // ---------------- driver ----------------
  // disturb: pulse start+mtlo while busy; with_mthi: assert mthi with start.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_mthi);
    int          lat, busy_cyc;
    logic [31:0] hi_before, lo_before;
    logic [63:0] e;
    @(negedge clk);
    start = 1'b1; op = o; SrcA = a; SrcB = b; mthi = with_mthi;
    hi_before = hi;
    lo_before = lo;
    exp_q.push_back(ref_model(o, a, b));
    @(posedge clk); #1;
    // Operands may change freely once the start edge has passed.
    start = 1'b0; mthi = 1'b0;
    op = 2'($urandom_range(0, 3)); SrcA = $urandom; SrcB = $urandom;
    if (with_mthi) check_eq("mthi_with_start_dropped", 64'(hi), 64'(hi_before));
    lat = 0;
    busy_cyc = busy ? 1 : 0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) busy_cyc++;
      if (disturb && lat == 5) begin
        start = 1'b1; mtlo = 1'b1; SrcA = $urandom; op = 2'($urandom_range(0, 3));
      end else if (disturb && lat == 6) begin
        start = 1'b0; mtlo = 1'b0;
      end else if (disturb && lat == 7) begin
        check_eq("mtlo_busy_dropped", 64'(lo), 64'(lo_before));
      end
    end
    check_eq($sformatf("latency op%0d", o), 64'(lat), 64'd33);
    check_eq($sformatf("busy_cycles op%0d", o), 64'(busy_cyc), 64'd33);
    e = exp_q.pop_front();
    check_eq($sformatf("hi op%0d a=%0h b=%0h", o, a, b), 64'(hi), 64'(e[63:32]));
    check_eq($sformatf("lo op%0d a=%0h b=%0h", o, a, b), 64'(lo), 64'(e[31:0]));
    @(posedge clk); #1;
    check_eq("done_single_pulse", 64'(done), 64'd0);
    check_eq("idle_after_done", 64'(busy), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'(($urandom_range(0, 1) == 1) ? 0 : 1);
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; SrcA = '0; SrcB = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_hi", 64'(hi), 64'd0);
    check_eq("reset_lo", 64'(lo), 64'd0);
    check_eq("reset_busy", 64'(busy), 64'd0);
    check_eq("reset_done", 64'(done), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
    run_op(MD_DIVU,  32'd100,       32'd0,         1'b0, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(MD_DIVU,  32'd10,        32'd3,         1'b1, 1'b0);

    // Asynchronous reset in the middle of a MULT.
    @(negedge clk);
    start = 1'b1; op = MD_MULT; SrcA = 32'hFFFF_FFFB; SrcB = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("midop_reset_busy", 64'(busy), 64'd0);
    check_eq("midop_reset_done", 64'(done), 64'd0);
    check_eq("midop_reset_hi", 64'(hi), 64'd0);
    check_eq("midop_reset_lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;
    run_op(MD_MULTU, 32'd6, 32'd7, 1'b0, 1'b0);

    // Idle moves to HI/LO.
    @(negedge clk); mthi = 1'b1; SrcA = 32'h1234;
    @(posedge clk); #1; mthi = 1'b0;
    check_eq("mthi_idle_hi", 64'(hi), 64'h1234);
    check_eq("mthi_idle_done", 64'(done), 64'd0);
    check_eq("mthi_idle_lo_kept", 64'(lo), 64'd42);
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; SrcA = 32'hCAFE_0001;
    @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b0;
    check_eq("mthi_mtlo_hi", 64'(hi), 64'hCAFE_0001);
    check_eq("mthi_mtlo_lo", 64'(lo), 64'hCAFE_0001);
    @(negedge clk); mthi = 1'b1; SrcA = 32'h1234;
    @(posedge clk); #1; mthi = 1'b0;
    run_op(MD_MULTU, 32'd5, 32'd6, 1'b0, 1'b1);

    // Randomized operations.
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0, 1'b0);
    end

    check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
